decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: RV32 instruction decoder with a small FIFO of decoded entries.
// Decoding happens as an instruction is accepted. Each buffer entry holds the
// already-decoded fields, so the head entry drives the outputs directly from
// storage.
module decode_pipe #(
  parameter int DEPTH  = 2,
  parameter bit CSR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic        out_illegal,
  output logic [31:0] dec_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Entry layout: {pc, imm, illegal, funct7, rs2, rs1, funct3, rd, opcode}
  localparam int EW = 32 + 32 + 1 + 7 + 5 + 5 + 3 + 5 + 7;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_dec_count;

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_imm;
  logic          w_illegal;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign in_ready  = (r_count != CNT_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Immediate extraction and legality check on the incoming word.
  // Words with instr[1:0] != 2'b11 never match a legal opcode and fall to default.
  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b1;
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        w_imm     = {in_instr[31:12], 12'b0};
        w_illegal = 1'b0;
      end
      OPC_JAL: begin
        w_imm     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        w_illegal = 1'b0;
      end
      OPC_BRANCH: begin
        w_imm     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        w_illegal = 1'b0;
      end
      OPC_STORE: begin
        w_imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_illegal = 1'b0;
      end
      OPC_JALR, OPC_LOAD, OPC_ARI_ITYPE: begin
        w_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
        w_illegal = 1'b0;
      end
      OPC_ARI_RTYPE: begin
        w_illegal = 1'b0;
      end
      OPC_CSR: begin
        // With CSR support disabled the opcode is just another illegal word.
        if (CSR_EN) begin
          w_imm     = {27'b0, in_instr[19:15]};
          w_illegal = 1'b0;
        end
      end
      default: begin
        w_imm     = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_entry = {in_pc, w_imm, w_illegal, in_instr[31:25], in_instr[24:20],
                    in_instr[19:15], in_instr[14:12], in_instr[11:7], in_instr[6:0]};

  // Entry storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy and consumed-entry counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dec_count <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_dec_count <= r_dec_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is forced to zero whenever the buffer is empty.
  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_opcode  = w_head[6:0];
  assign out_rd      = w_head[11:7];
  assign out_funct3  = w_head[14:12];
  assign out_rs1     = w_head[19:15];
  assign out_rs2     = w_head[24:20];
  assign out_funct7  = w_head[31:25];
  assign out_illegal = w_head[32];
  assign out_imm     = w_head[64:33];
  assign out_pc      = w_head[96:65];
  assign dec_count   = r_dec_count;

endmodule
